mmr_trigger_collector: RTL and testbench

- Slave-side producer of the trigger status register (TSR) bank consumed by the MMR trigger interface.
- Collects single-cycle trigger event pulses from datapath blocks into sticky per-bit status flags (tsr).
- Clears flags on write-1-to-clear pulses (tsr_invpulses) driven by the MMR master.
- Also provides per-register saturating lost-event counters and a masked, level interrupt.

---
 rtl/mmr_trigger_collector.sv | 43 ++++
 tb/tb_mmr_trigger_collector.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mmr_trigger_collector.sv
// mmr_trigger_collector: sticky trigger status flags with W1C clear, saturating lost-event counters and a masked level irq
module mmr_trigger_collector #(
  parameter int N = 4,
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [N-1:0][WIDTH-1:0]       trigger_pulses,
  output logic [N-1:0][WIDTH-1:0]       tsr,
  input  logic [N-1:0][WIDTH-1:0]       tsr_invpulses,
  input  logic [N-1:0][WIDTH-1:0]       irq_mask,
  output logic                          irq,
  output logic [N-1:0][CNT_WIDTH-1:0]   lost_count,
  input  logic [N-1:0]                  lost_clear
);
  logic [N-1:0][WIDTH-1:0]     tsr_n;
  logic [N-1:0][CNT_WIDTH-1:0] cnt_n;
  logic [N-1:0]                lost;
  logic                        irq_n;
  always_comb begin
    tsr_n = '0;
    cnt_n = '0;
    lost  = '0;
    for (int i = 0; i < N; i++) begin
      tsr_n[i] = trigger_pulses[i] | (tsr[i] & ~tsr_invpulses[i]);
      lost[i]  = |(trigger_pulses[i] & tsr[i] & ~tsr_invpulses[i]);
      cnt_n[i] = lost_clear[i] ? CNT_WIDTH'(lost[i]) :
                 (lost[i] && lost_count[i] != '1) ? lost_count[i] + CNT_WIDTH'(1) : lost_count[i];
    end
    irq_n = |(tsr_n & irq_mask);
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      tsr        <= '0;
      lost_count <= '0;
      irq        <= 1'b0;
    end else begin
      tsr        <= tsr_n;
      lost_count <= cnt_n;
      irq        <= irq_n;
    end
endmodule

// File: tb/tb_mmr_trigger_collector.sv
// tb_mmr_trigger_collector: directed checks of flags, clears, lost counters, irq and async reset
module tb_mmr_trigger_collector;
  logic              clock = 1'b0;
  logic              resetn;
  logic [3:0][31:0]  trigger_pulses, tsr_invpulses, irq_mask, tsr;
  logic [3:0][3:0]   lost_count;
  logic [3:0]        lost_clear;
  logic              irq;
  int total = 0;
  int bad = 0;

  mmr_trigger_collector #(.N(4), .WIDTH(32), .CNT_WIDTH(4)) dut (
    .clock(clock), .resetn(resetn), .trigger_pulses(trigger_pulses), .tsr(tsr),
    .tsr_invpulses(tsr_invpulses), .irq_mask(irq_mask), .irq(irq),
    .lost_count(lost_count), .lost_clear(lost_clear)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    trigger_pulses = '0;
    tsr_invpulses  = '0;
    lost_clear     = '0;
  endtask

  task automatic clear_flags();
    tsr_invpulses = '1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    irq_mask = '0;
    trigger_pulses[0] = 32'hFFFF_FFFF;
    tick();
    tick();
    total++; if (tsr !== '0) begin bad++; $display("FAIL reset_tsr got=%h want=0", tsr); end
    total++; if (lost_count !== '0) begin bad++; $display("FAIL reset_lost got=%h want=0", lost_count); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    idle();
    resetn = 1'b1;
    tick();
    trigger_pulses[1] = 32'h8;
    tick();
    idle();
    total++; if (tsr[1] !== 32'h8) begin bad++; $display("FAIL set_bit3 got=%h want=00000008", tsr[1]); end
    tick();
    tick();
    total++; if (tsr[1] !== 32'h8) begin bad++; $display("FAIL sticky_bit3 got=%h want=00000008", tsr[1]); end
    clear_flags();
  endtask

  task automatic test_clear();
    trigger_pulses[2] = 32'hF0;
    tick();
    idle();
    tsr_invpulses[2] = 32'h30;
    tick();
    idle();
    total++; if (tsr[2] !== 32'hC0) begin bad++; $display("FAIL clear got=%h want=000000c0", tsr[2]); end
    trigger_pulses[2] = 32'h30;
    tick();
    idle();
    tsr_invpulses[2] = 32'h30;
    trigger_pulses[2] = 32'h10;
    tick();
    idle();
    total++; if (tsr[2] !== 32'hD0) begin bad++; $display("FAIL set_over_clear got=%h want=000000d0", tsr[2]); end
    total++; if (lost_count[2] !== 4'd0) begin bad++; $display("FAIL set_clear_not_lost got=%0d want=0", lost_count[2]); end
    clear_flags();
  endtask

  task automatic test_lost();
    trigger_pulses[0] = 32'h1;
    tick();
    total++; if (lost_count[0] !== 4'd0) begin bad++; $display("FAIL first_set_not_lost got=%0d want=0", lost_count[0]); end
    trigger_pulses[0] = 32'h3;
    tick();
    idle();
    total++; if (lost_count[0] !== 4'd1) begin bad++; $display("FAIL lost_once_per_cycle got=%0d want=1", lost_count[0]); end
    total++; if (tsr[0] !== 32'h3) begin bad++; $display("FAIL lost_tsr got=%h want=00000003", tsr[0]); end
    lost_clear[0] = 1'b1;
    tick();
    idle();
    total++; if (lost_count[0] !== 4'd0) begin bad++; $display("FAIL lost_clear got=%0d want=0", lost_count[0]); end
    trigger_pulses[0] = 32'h1;
    repeat (5) tick();
    idle();
    total++; if (lost_count[0] !== 4'd5) begin bad++; $display("FAIL held_pulse got=%0d want=5", lost_count[0]); end
  endtask

  task automatic test_saturation();
    trigger_pulses[3] = 32'h1;
    tick();
    repeat (20) tick();
    total++; if (lost_count[3] !== 4'd15) begin bad++; $display("FAIL saturate got=%0d want=15", lost_count[3]); end
    lost_clear[3] = 1'b1;
    tick();
    idle();
    total++; if (lost_count[3] !== 4'd1) begin bad++; $display("FAIL clear_with_lost got=%0d want=1", lost_count[3]); end
    tick();
    total++; if (lost_count[3] !== 4'd1) begin bad++; $display("FAIL hold_after_clear got=%0d want=1", lost_count[3]); end
    total++; if (lost_count[0] !== 4'd5) begin bad++; $display("FAIL word_independent got=%0d want=5", lost_count[0]); end
  endtask

  task automatic test_irq();
    clear_flags();
    irq_mask[1] = 32'h1;
    trigger_pulses[1] = 32'h2;
    tick();
    idle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_unmasked got=%b want=0", irq); end
    trigger_pulses[1] = 32'h1;
    tick();
    idle();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", irq); end
    total++; if (tsr[1] !== 32'h3) begin bad++; $display("FAIL irq_tsr got=%h want=00000003", tsr[1]); end
    tsr_invpulses[1] = 32'h1;
    tick();
    idle();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b want=0", irq); end
    irq_mask[1] = 32'h3;
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_mask_change got=%b want=1", irq); end
  endtask

  task automatic test_async_reset();
    clear_flags();
    trigger_pulses[0] = 32'hFF;
    trigger_pulses[1] = 32'h2;
    repeat (3) tick();
    total++; if (tsr[0] !== 32'hFF) begin bad++; $display("FAIL burst_tsr got=%h want=000000ff", tsr[0]); end
    total++; if (lost_count[0] !== 4'd7) begin bad++; $display("FAIL burst_lost got=%0d want=7", lost_count[0]); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL burst_irq got=%b want=1", irq); end
    #2 resetn = 1'b0;
    #1;
    total++; if (tsr !== '0) begin bad++; $display("FAIL async_tsr got=%h want=0", tsr); end
    total++; if (lost_count !== '0) begin bad++; $display("FAIL async_lost got=%h want=0", lost_count); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq got=%b want=0", irq); end
    tick();
    idle();
    resetn = 1'b1;
    tick();
    tick();
    total++; if (tsr !== '0) begin bad++; $display("FAIL stale_tsr got=%h want=0", tsr); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL stale_irq got=%b want=0", irq); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_lost();
    test_saturation();
    test_irq();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
